mlp_layer_sequencer: RTL and testbench
======================================

Name: mlp_layer_sequencer

Overview:
- Controller and MAC that drives the MLP weight/activation memory from the compute side.
- On start, pulses a one-cycle load into the memory. Then walks every layer and neuron, reading inputs, weights and bias, computing a fixed-point dot product plus bias with activation, and writing each result back.
- Captures the final-layer results on its own output vector and signals done.
- Sits between the testbench/top-level control and the memory block.

Parameters:
- M, 3: number of network layers including input; M-1 compute layers.
- N, 2: neurons per layer, and inputs per neuron.
- QM, 3: integer bits of activations and bias.
- QN, 5: fraction bits of activations and bias.
- WM, 3: integer bits of weights.
- WN, 5: fraction bits of weights.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle request to run the whole network; ignored unless IDLE.
- initial_flag, out, 1: one-cycle pulse telling memory to load x/w/b.
- read_en, out, 1: memory read strobe.
- layer_addr, out, $clog2(M-1): current compute layer.
- neuron_addr, out, $clog2(N): current neuron; also the write index.
- inputs, in, [N-1:0] x (QM+QN) signed: current-layer activations from memory.
- weights, in, [N-1:0] x (WM+WN) signed: weights of the addressed neuron.
- bias, in, QM+QN signed: bias of the addressed neuron.
- write_en, out, 1: one-cycle write of result at neuron_addr.
- result, out, QM+QN signed: activated, saturated neuron output.
- busy, out, 1: high from the cycle after an accepted start until DONE ends.
- done, out, 1: one-cycle pulse when the last neuron of the last layer is written.
- y, out, [N-1:0] x (QM+QN) signed: final-layer outputs.
- y_valid, out, 1: y is valid; set with done, cleared on next accepted start.

Behaviour:
- Reset: state IDLE. All outputs are 0: initial_flag, read_en, write_en, result, addresses, busy, done, y[*], y_valid. Accumulator and counters are cleared.
- Reset mid-operation aborts immediately; the next start performs a fresh LOAD.
- The FSM states are IDLE, LOAD, READ, MAC, WRITE, DONE.
  - IDLE: on start, go to LOAD and clear y_valid.
  - LOAD: initial_flag=1 for exactly one cycle; layer=0, neuron=0; go to READ.
  - READ: read_en=1 for one cycle. Memory output is combinational. Latch inputs[], weights[] and bias into local registers at this edge. Clear accumulator and go to MAC.
  - MAC: N cycles, one product per cycle, index 0..N-1 in order. After the Nth product, go to WRITE.
  - WRITE: write_en=1 for one cycle, with result and neuron_addr stable. If layer==M-2, also capture y[neuron]<=result.
    - If neuron<N-1: neuron++ and go to READ.
    - Else if layer<M-2: neuron=0, layer++, go to READ.
    - Else: go to DONE.
  - DONE: done=1 and y_valid<=1 for one cycle; return to IDLE.
- initial_flag, read_en and write_en are mutually exclusive in every cycle.
- Outside READ/WRITE, layer_addr and neuron_addr hold their values.
- Latency: done is asserted (M-1)*N*(N+2)+2 cycles after the start cycle. For the default parameters that is 18.
- Arithmetic:
  - Each product is inputs[i]*weights[i] at full precision, QN+WN fraction bits.
  - Accumulator width is QM+QN+WM+WN+$clog2(N)+1, so it cannot overflow.
  - Bias is sign-extended and shifted left by WN before adding.
  - Final value = (acc + bias<<WN) >>> WN, an arithmetic shift that floors toward -inf.
  - Activation is applied next (see Optional Feature).
  - Then saturate to [-2^(QM+QN-1), 2^(QM+QN-1)-1].
- Memory bank toggling is tied to the write of neuron_addr==N-1. The sequencer never writes out of order and never reorders neurons.
- start asserted while busy has no effect.

Optional Feature:
- MLP_RELU_EN defined: negative pre-saturation values become 0 on every layer; outputs are therefore in [0, 2^(QM+QN-1)-1].
- Undefined: identity activation; signed saturation only.

Test Plan:
- Unit scaling (Q3.5, 1.0=32): x={32,32}, all w=16, b=0 -> every write result=32, y={32,32}. done arrives 18 cycles after start; write order is (L0,N0),(L0,N1),(L1,N0),(L1,N1).
- Saturation: x={96,96}, all w=96 -> layer-0 results=127, final y={127,127}. Nothing wraps negative.
- Negative path: x={32,32}, all w=-32 -> pre-activation -64. With MLP_RELU_EN, results=0 and y={0,0}. Without it, layer 0 is -64 and layer 1 saturates to 127.
- Rounding: x={1,0}, w0=16, b=0 gives 0. x={-1,0}, same w, gives -1 (floor), checked without the macro.
- Bias path: x={0,0}, w=0, b={5,-7} per layer -> results=5 and -7 (without the macro). y equals the last-layer bias.
- Control:
  - A start pulse while busy is ignored; there is no second LOAD.
  - Assert rst during MAC of L0,N1 -> next cycle all outputs are 0 and the state is IDLE.
  - A following start reruns the full sequence with a fresh initial_flag and matching results.

Source files
------------

// File: rtl/mlp_layer_sequencer_if.sv
// Compute-side bus of the MLP layer sequencer: run control, memory access strobes and final outputs.
// The sequencer holds the master modport; the memory/top-level side holds the slave modport.
interface mlp_layer_sequencer_if #(
  parameter int M  = 3,
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
);
  localparam int AW = QM + QN;
  localparam int WW = WM + WN;
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  // Strobes are single-cycle and level-qualified: initial_flag, read_en and write_en
  // are never high together; memory data is combinational and sampled in the read_en
  // cycle; result/neuron_addr are stable for the whole write_en cycle.
  logic                   start;
  logic                   initial_flag;
  logic                   read_en;
  logic [LW-1:0]          layer_addr;
  logic [NW-1:0]          neuron_addr;
  logic [N-1:0][AW-1:0]   inputs;
  logic [N-1:0][WW-1:0]   weights;
  logic signed [AW-1:0]   bias;
  logic                   write_en;
  logic signed [AW-1:0]   result;
  logic                   busy;
  logic                   done;
  logic [N-1:0][AW-1:0]   y;
  logic                   y_valid;
  logic [2:0]             state;

  modport master (
    input  start, inputs, weights, bias,
    output initial_flag, read_en, layer_addr, neuron_addr, write_en, result,
           busy, done, y, y_valid, state
  );

  modport slave (
    output start, inputs, weights, bias,
    input  initial_flag, read_en, layer_addr, neuron_addr, write_en, result,
           busy, done, y, y_valid, state
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Layer/neuron sequencer with a serial fixed-point MAC; writes each neuron result back to memory.
// Define MLP_RELU_EN for ReLU activation on every layer; otherwise identity with signed saturation.
module mlp_layer_sequencer #(
  parameter int M  = 3,
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
) (
  input  logic clk,
  input  logic rst,
  mlp_layer_sequencer_if.master bus
);
  localparam int AW   = QM + QN;
  localparam int WW   = WM + WN;
  localparam int LW   = (M > 2) ? $clog2(M - 1) : 1;
  localparam int NW   = (N > 1) ? $clog2(N) : 1;
  localparam int ACCW = AW + WW + $clog2(N) + 1;
  localparam int SW   = ACCW + 1;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (AW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [LW-1:0]          layer;
  logic [NW-1:0]          neuron;
  logic [NW-1:0]          k;
  logic [N-1:0][AW-1:0]   x_r;
  logic [N-1:0][WW-1:0]   w_r;
  logic signed [AW-1:0]   b_r;
  logic signed [ACCW-1:0] acc;
  logic signed [AW+WW-1:0] prod;
  logic signed [SW-1:0]   sum, shifted, act;
  logic signed [AW-1:0]   res;
  logic [N-1:0][AW-1:0]   y_r;
  logic                   y_valid_r;
  logic                   last_neuron, last_layer, last_k;

  assign last_neuron = (neuron == NW'(N - 1));
  assign last_layer  = (layer == LW'(M - 2));
  assign last_k      = (k == NW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_READ;
      S_READ:  state_nxt = S_MAC;
      S_MAC:   if (last_k) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (last_neuron && last_layer) ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.initial_flag = (state == S_LOAD);
    bus.read_en      = (state == S_READ);
    bus.write_en     = (state == S_WRITE);
    bus.done         = (state == S_DONE);
    bus.busy         = (state != S_IDLE);
    bus.state        = state;
  end

  // Full-precision product; the size cast sign-extends into the accumulator.
  assign prod    = $signed(x_r[k]) * $signed(w_r[k]);
  assign sum     = SW'(acc) + (SW'(b_r) <<< WN);
  assign shifted = sum >>> WN;

  always_comb begin
    act = shifted;
`ifdef MLP_RELU_EN
    if (shifted < 0) act = '0;
`endif
    if (act > MAXV)      res = MAXV[AW-1:0];
    else if (act < MINV) res = MINV[AW-1:0];
    else                 res = act[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer     <= '0;
      neuron    <= '0;
      k         <= '0;
      x_r       <= '0;
      w_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      y_r       <= '0;
      y_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) y_valid_r <= 1'b0;
        S_LOAD: begin
          layer  <= '0;
          neuron <= '0;
        end
        S_READ: begin
          x_r <= bus.inputs;
          w_r <= bus.weights;
          b_r <= bus.bias;
          acc <= '0;
          k   <= '0;
        end
        S_MAC: begin
          acc <= acc + ACCW'(prod);
          k   <= k + 1'b1;
        end
        S_WRITE: begin
          if (last_layer) y_r[neuron] <= res;
          if (!last_neuron) begin
            neuron <= neuron + 1'b1;
          end else if (!last_layer) begin
            neuron <= '0;
            layer  <= layer + 1'b1;
          end
        end
        S_DONE: y_valid_r <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.layer_addr  = layer;
  assign bus.neuron_addr = neuron;
  assign bus.result      = res;
  assign bus.y           = y_r;
  assign bus.y_valid     = y_valid_r;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer with a behavioural ping-pong activation memory.
// Expected values are hand-computed Q3.5 results; ReLU expectations apply when MLP_RELU_EN is defined.
module tb_mlp_layer_sequencer;
  localparam int M = 3, N = 2, QM = 3, QN = 5, WM = 3, WN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.M(M), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) bus ();
  mlp_layer_sequencer #(.M(M), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [7:0] x_cfg [2];
  logic signed [7:0] b_cfg [2];
  logic signed [7:0] w_cfg;
  logic signed [7:0] mem_in [2];
  logic signed [7:0] mem_nxt [2];

  assign bus.inputs  = {mem_in[1], mem_in[0]};
  assign bus.weights = {w_cfg, w_cfg};
  assign bus.bias    = b_cfg[bus.neuron_addr];

  // Memory model: load on initial_flag, buffer writes, swap banks on the last neuron.
  always @(posedge clk) begin
    if (bus.initial_flag) begin
      mem_in[0] <= x_cfg[0];
      mem_in[1] <= x_cfg[1];
    end else if (bus.write_en) begin
      mem_nxt[bus.neuron_addr] <= bus.result;
      if (bus.neuron_addr == 1'b1) begin
        mem_in[0] <= mem_nxt[0];
        mem_in[1] <= bus.result;
      end
    end
  end

  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         addr_q [$];
  int         done_cyc, load_cnt, excl_cnt;
  logic       busy1, yv1;

  task automatic set_cfg(input int x0, input int x1, input int w, input int b0, input int b1);
    x_cfg[0] = 8'(x0);
    x_cfg[1] = 8'(x1);
    w_cfg    = 8'(w);
    b_cfg[0] = 8'(b0);
    b_cfg[1] = 8'(b1);
  endtask

  // Pulses start, then records strobes and writes per cycle until done or the budget expires.
  task automatic run_net(input int budget, input int extra_start);
    obs_q.delete();
    addr_q.delete();
    done_cyc = -1;
    load_cnt = 0;
    excl_cnt = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      bus.start = (n == extra_start);
      if (n == 1) begin
        busy1 = bus.busy;
        yv1   = bus.y_valid;
      end
      if (bus.initial_flag) load_cnt++;
      if (int'(bus.initial_flag) + int'(bus.read_en) + int'(bus.write_en) > 1) excl_cnt++;
      if (bus.write_en) begin
        obs_q.push_back(bus.result);
        addr_q.push_back(int'(bus.layer_addr) * N + int'(bus.neuron_addr));
      end
      if (bus.done) begin
        done_cyc = n;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.initial_flag, bus.read_en, bus.write_en, bus.busy, bus.done, bus.y_valid} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.initial_flag, bus.read_en, bus.write_en, bus.busy, bus.done, bus.y_valid});
    end
    n_cmp++;
    if ({bus.result, bus.layer_addr, bus.neuron_addr, bus.y} !== 26'b0) begin
      n_bad++;
      $display("FAIL reset_data got result=%0d layer=%0d neuron=%0d y=%h want all 0",
               bus.result, bus.layer_addr, bus.neuron_addr, bus.y);
    end
    n_cmp++;
    if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", bus.state); end
    rst = 1'b0;
  endtask

  task automatic test_unit;
    set_cfg(32, 32, 16, 0, 0);
    exp_q = '{8'd32, 8'd32, 8'd32, 8'd32};
    run_net(40, 0);
    n_cmp++;
    if (done_cyc !== 18) begin n_bad++; $display("FAIL unit_latency got %0d want 18", done_cyc); end
    n_cmp++;
    if (load_cnt !== 1 || excl_cnt !== 0) begin
      n_bad++; $display("FAIL unit_strobes got loads=%0d overlaps=%0d want 1/0", load_cnt, excl_cnt);
    end
    n_cmp++;
    if (busy1 !== 1'b1 || yv1 !== 1'b0) begin
      n_bad++; $display("FAIL unit_start got busy=%b y_valid=%b want 1/0", busy1, yv1);
    end
    n_cmp++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL unit_nwrites got %0d want 4", obs_q.size()); end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || addr_q[i] !== i) begin
        n_bad++;
        $display("FAIL unit_write[%0d] got res=%0d addr=%0d want res=%0d addr=%0d",
                 i, $signed(obs_q[i]), addr_q[i], $signed(exp_q[i]), i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.y_valid !== 1'b1 || bus.y !== {8'd32, 8'd32}) begin
      n_bad++; $display("FAIL unit_y got valid=%b y=%h want 1 2020", bus.y_valid, bus.y);
    end
  endtask

  task automatic test_saturation;
    set_cfg(96, 96, 96, 0, 0);
    exp_q = '{8'd127, 8'd127, 8'd127, 8'd127};
    run_net(40, 0);
    n_cmp++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL sat_nwrites got %0d want 4", obs_q.size()); end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL sat_write[%0d] got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.y !== {8'd127, 8'd127}) begin n_bad++; $display("FAIL sat_y got %h want 7f7f", bus.y); end
  endtask

  task automatic test_negative;
    logic [15:0] exp_y;
    set_cfg(32, 32, -32, 0, 0);
`ifdef MLP_RELU_EN
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0};
    exp_y = 16'h0000;
`else
    exp_q = '{8'hc0, 8'hc0, 8'd127, 8'd127};
    exp_y = 16'h7f7f;
`endif
    run_net(40, 0);
    n_cmp++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL neg_nwrites got %0d want 4", obs_q.size()); end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL neg_write[%0d] got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.y !== exp_y) begin n_bad++; $display("FAIL neg_y got %h want %h", bus.y, exp_y); end
  endtask

  task automatic test_rounding;
    logic [7:0] exp_neg;
    set_cfg(1, 0, 16, 0, 0);
    run_net(40, 0);
    n_cmp++;
    if (obs_q.size() !== 4 || obs_q[0] !== 8'd0 || obs_q[3] !== 8'd0) begin
      n_bad++; $display("FAIL round_pos got n=%0d first=%0d want n=4 value 0", obs_q.size(), $signed(obs_q[0]));
    end
`ifdef MLP_RELU_EN
    exp_neg = 8'd0;
`else
    exp_neg = 8'hff;
`endif
    set_cfg(-1, 0, 16, 0, 0);
    run_net(40, 0);
    n_cmp++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL round_nwrites got %0d want 4", obs_q.size()); end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_neg) begin
        n_bad++; $display("FAIL round_neg[%0d] got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_neg));
      end
    end
  endtask

  task automatic test_bias;
    logic [7:0] exp_n1;
`ifdef MLP_RELU_EN
    exp_n1 = 8'd0;
`else
    exp_n1 = 8'hf9;
`endif
    set_cfg(0, 0, 0, 5, -7);
    exp_q = '{8'd5, exp_n1, 8'd5, exp_n1};
    run_net(40, 0);
    n_cmp++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL bias_nwrites got %0d want 4", obs_q.size()); end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bias_write[%0d] got %0d want %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.y !== {exp_n1, 8'd5}) begin n_bad++; $display("FAIL bias_y got %h want %h", bus.y, {exp_n1, 8'd5}); end
  endtask

  task automatic test_busy_start;
    set_cfg(32, 32, 16, 0, 0);
    run_net(40, 5);
    n_cmp++;
    if (load_cnt !== 1 || done_cyc !== 18) begin
      n_bad++; $display("FAIL busy_start got loads=%0d done_at=%0d want 1/18", load_cnt, done_cyc);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.state !== 3'd0) begin
      n_bad++; $display("FAIL busy_idle got busy=%b state=%0d want 0/0", bus.busy, bus.state);
    end
  endtask

  task automatic test_reset_abort;
    set_cfg(32, 32, 16, 0, 0);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if (bus.state !== 3'd3 || bus.neuron_addr !== 1'b1 || bus.layer_addr !== 1'b0) begin
      n_bad++; $display("FAIL abort_pre got state=%0d L=%0d N=%0d want 3/0/1",
                        bus.state, bus.layer_addr, bus.neuron_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.initial_flag, bus.read_en, bus.write_en, bus.busy, bus.done, bus.y_valid} !== 6'b0 ||
        {bus.result, bus.layer_addr, bus.neuron_addr, bus.y} !== 26'b0 || bus.state !== 3'd0) begin
      n_bad++; $display("FAIL abort_clear got state=%0d busy=%b res=%0d y=%h yv=%b want all 0",
                        bus.state, bus.busy, bus.result, bus.y, bus.y_valid);
    end
    rst = 1'b0;
    exp_q = '{8'd32, 8'd32, 8'd32, 8'd32};
    run_net(40, 0);
    n_cmp++;
    if (load_cnt !== 1 || done_cyc !== 18 || obs_q.size() !== 4) begin
      n_bad++; $display("FAIL abort_rerun got loads=%0d done_at=%0d n=%0d want 1/18/4",
                        load_cnt, done_cyc, obs_q.size());
    end
    foreach (obs_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || addr_q[i] !== i) begin
        n_bad++; $display("FAIL abort_write[%0d] got res=%0d addr=%0d want %0d/%0d",
                          i, $signed(obs_q[i]), addr_q[i], $signed(exp_q[i]), i);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    test_reset();
    test_unit();
    test_saturation();
    test_negative();
    test_rounding();
    test_bias();
    test_busy_start();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
